// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the instruction-queue front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_queue_pkg;

  localparam int DataLength = 31;
  localparam int PcLength   = 31;
  localparam int Zero       = 0;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // Default first fetch address after reset; the top exposes it as RESET_PC.
  localparam logic [PcLength:0] DefaultResetPc = 32'h0000_0000;

  // One queued fetch result: the address it was fetched from and the word.
  typedef struct packed {
    logic [PcLength:0]   pc;
    logic [DataLength:0] instr;
  } entry_t;

endpackage

// File: rtl/instr_queue_sync_fifo.sv
// Generic synchronous FIFO with wrap-around pointers, occupancy count and a clear.
// Latency: a pushed entry is visible on pop_dat from the next cycle; pop_dat is read combinationally.
// Backpressure: push is ignored when full, pop is ignored when empty; clr beats push/pop.
module instr_queue_sync_fifo #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_dat,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_dat,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FullCount = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[head_q];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    do_push = push & ~full & ~clr;
    do_pop  = pop & ~empty & ~clr;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_dat;
  end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue: owns fetch PC, requests words from fc, buffers {pc,instr}, dispatches to dc.
// Latency: a word accepted at edge N is dispatched (registered) at edge N+1 at the earliest.
// Backpressure: fetch request withdrawn while full; ROB stall holds dispatch, queue keeps filling.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int                DEPTH    = 16,
  parameter int                ADDR_W   = 4,
  parameter logic [PcLength:0] RESET_PC = DefaultResetPc
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_stall_from_rob,
  input  logic                  is_exception_from_rob,
  input  logic [PcLength:0]     pc_from_rob,
  input  logic                  is_stall_from_fc,
  input  logic                  is_finish_from_fc,
  input  logic                  is_instr_from_fc,
  input  logic [DataLength:0]   instr_from_fc,
  output logic                  is_empty_to_fc,
  output logic [PcLength:0]     pc_to_fc,
  output logic                  is_receive_to_fc,
  output logic                  is_empty_to_dc,
  output logic [DataLength:0]   instr_to_dc,
  output logic [PcLength:0]     pc_to_dc
);

  entry_t            push_ent, pop_ent;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W:0]   unused_count;

  logic [PcLength:0]   fetch_pc_q, fetch_pc_d;
  logic                dc_empty_q, dc_empty_d;
  logic [DataLength:0] dc_instr_q, dc_instr_d;
  logic [PcLength:0]   dc_pc_q, dc_pc_d;

  // fc stalls only stretch its own completion; the held request needs no action here.
  logic unused_fc_stall;
  assign unused_fc_stall = is_stall_from_fc;

  instr_queue_sync_fifo #(
    .WIDTH  ($bits(entry_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (is_exception_from_rob),
    .push     (fifo_push),
    .push_dat (push_ent),
    .pop      (fifo_pop),
    .pop_dat  (pop_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (unused_count)
  );

  // Fetch request, accept handshake and dispatch enable.
  always_comb begin
    is_empty_to_fc   = fifo_full | is_exception_from_rob | rst;
    pc_to_fc         = fetch_pc_q;
    is_receive_to_fc = is_finish_from_fc & is_instr_from_fc & ~is_empty_to_fc;
    fifo_push        = is_receive_to_fc;
    push_ent.pc      = fetch_pc_q;
    push_ent.instr   = instr_from_fc;
    fifo_pop         = ~fifo_empty & ~is_stall_from_rob & ~is_exception_from_rob & ~rst;
  end

  // Next fetch PC: redirect wins, otherwise advance one word per accepted result.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (is_exception_from_rob) begin
      fetch_pc_d = pc_from_rob;
    end else if (is_receive_to_fc) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // Dispatch register: load the head on pop, otherwise mark empty and hold data.
  always_comb begin
    dc_empty_d = True;
    dc_instr_d = dc_instr_q;
    dc_pc_d    = dc_pc_q;
    if (fifo_pop) begin
      dc_empty_d = False;
      dc_instr_d = pop_ent.instr;
      dc_pc_d    = pop_ent.pc;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      dc_empty_q <= True;
      dc_instr_q <= Zero[DataLength:0];
      dc_pc_q    <= Zero[PcLength:0];
    end else begin
      fetch_pc_q <= fetch_pc_d;
      dc_empty_q <= dc_empty_d;
      dc_instr_q <= dc_instr_d;
      dc_pc_q    <= dc_pc_d;
    end
  end

  assign is_empty_to_dc = dc_empty_q;
  assign instr_to_dc    = dc_instr_q;
  assign pc_to_dc       = dc_pc_q;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios then randomized traffic vs a queue model.
// Latency: checks combinational fc outputs mid-cycle and registered dc outputs 1 time unit after posedge.
// Backpressure: model applies full / ROB stall / exception rules directly.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_stall_from_rob;
  logic        is_exception_from_rob;
  logic [31:0] pc_from_rob;
  logic        is_stall_from_fc;
  logic        is_finish_from_fc;
  logic        is_instr_from_fc;
  logic [31:0] instr_from_fc;
  logic        is_empty_to_fc;
  logic [31:0] pc_to_fc;
  logic        is_receive_to_fc;
  logic        is_empty_to_dc;
  logic [31:0] instr_to_dc;
  logic [31:0] pc_to_dc;

  always #5 clk = ~clk;

  instr_queue #(
    .DEPTH    (16),
    .ADDR_W   (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .is_stall_from_rob     (is_stall_from_rob),
    .is_exception_from_rob (is_exception_from_rob),
    .pc_from_rob           (pc_from_rob),
    .is_stall_from_fc      (is_stall_from_fc),
    .is_finish_from_fc     (is_finish_from_fc),
    .is_instr_from_fc      (is_instr_from_fc),
    .instr_from_fc         (instr_from_fc),
    .is_empty_to_fc        (is_empty_to_fc),
    .pc_to_fc              (pc_to_fc),
    .is_receive_to_fc      (is_receive_to_fc),
    .is_empty_to_dc        (is_empty_to_dc),
    .instr_to_dc           (instr_to_dc),
    .pc_to_dc              (pc_to_dc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue of {pc, instr} plus the expected fetch PC and dc outputs.
  logic [63:0] mq[$];
  logic [31:0] m_fpc;
  logic        m_empty_dc;
  logic [31:0] m_instr;
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs at negedge, check fc outputs, then update model and check dc outputs.
  task automatic cyc(input logic r, input logic sr, input logic ex, input logic [31:0] prob,
                     input logic sfc, input logic fin, input logic ii, input logic [31:0] ins);
    logic        exp_efc, exp_rcv;
    logic [63:0] ent;
    @(negedge clk);
    rst = r; is_stall_from_rob = sr; is_exception_from_rob = ex; pc_from_rob = prob;
    is_stall_from_fc = sfc; is_finish_from_fc = fin; is_instr_from_fc = ii; instr_from_fc = ins;
    #1;
    exp_efc = (mq.size() == 16) || ex || r;
    exp_rcv = fin && ii && !exp_efc;
    chk("empty_to_fc", {31'b0, is_empty_to_fc}, {31'b0, exp_efc});
    chk("pc_to_fc", pc_to_fc, m_fpc);
    chk("receive_to_fc", {31'b0, is_receive_to_fc}, {31'b0, exp_rcv});
    @(posedge clk);
    if (r) begin
      mq.delete(); m_fpc = 32'h0; m_empty_dc = 1'b1; m_instr = 32'h0; m_pc = 32'h0;
    end else if (ex) begin
      mq.delete(); m_fpc = prob; m_empty_dc = 1'b1;
    end else begin
      if (mq.size() > 0 && !sr) begin
        ent = mq.pop_front();
        m_pc = ent[63:32]; m_instr = ent[31:0]; m_empty_dc = 1'b0;
      end else begin
        m_empty_dc = 1'b1;
      end
      if (exp_rcv) begin
        mq.push_back({m_fpc, ins});
        m_fpc = m_fpc + 32'd4;
      end
    end
    #1;
    chk("empty_to_dc", {31'b0, is_empty_to_dc}, {31'b0, m_empty_dc});
    chk("instr_to_dc", instr_to_dc, m_instr);
    chk("pc_to_dc", pc_to_dc, m_pc);
  endtask

  initial begin
    rst = 1'b1; is_stall_from_rob = 1'b0; is_exception_from_rob = 1'b0; pc_from_rob = 32'h0;
    is_stall_from_fc = 1'b0; is_finish_from_fc = 1'b0; is_instr_from_fc = 1'b0; instr_from_fc = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    mq.delete(); m_fpc = 32'h0; m_empty_dc = 1'b1; m_instr = 32'h0; m_pc = 32'h0;
    chk("reset_empty_dc", {31'b0, is_empty_to_dc}, 32'h1);
    chk("reset_instr_dc", instr_to_dc, 32'h0);
    chk("reset_pc_dc", pc_to_dc, 32'h0);
    chk("reset_pc_fc", pc_to_fc, 32'h0);

    // Two fetches with 4-cycle fc latency.
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, (k == 0) ? 32'h0000_0013 : 32'h0010_0093);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Fill under ROB stall: 20 returns offered, only 16 accepted.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 1, 1, 32'hA000_0000 + i);
    chk("full_pc_fc", pc_to_fc, 32'h40);
    chk("full_req", {31'b0, is_empty_to_fc}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("drain_pc", pc_to_dc, 32'(i * 4));
    end
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h0000_0040);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("resume_pc", pc_to_dc, 32'h40);

    // Load data result must be ignored.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);

    // Exception with 3 queued and a same-cycle result.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 1, 1, 32'hB000_0000 + i);
    cyc(0, 1, 1, 32'h1000, 0, 1, 1, 32'hBAD0_0000);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'hC000_0001);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("redirect_pc", pc_to_dc, 32'h1000);

    // fc stall: request held, nothing pushed.
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);

    // Reset mid-stream with 5 queued.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 1, 1, 32'hD000_0000 + i);
    cyc(1, 1, 0, 0, 0, 1, 1, 32'hEEEE_EEEE);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_pc_fc", pc_to_fc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 3,
          $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 85,
          $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
